// File: rtl/pc_module.sv
// Program counter register for the single-issue core: a plain WIDTH-bit state element
// that loads the upstream-selected next-PC every rising clk edge, with async active-low reset.
module pc_module #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PC_Next,
    output logic [WIDTH-1:0] PC
);

    logic [WIDTH-1:0] r_pc;

    // Reset dominates any coincident clk edge, so PC never picks up an undriven PC_Next during reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_VALUE;
        end else begin
            r_pc <= PC_Next;
        end
    end

    assign PC = r_pc;

endmodule

// File: tb/tb_pc_module.sv
// Directed bench for pc_module: expected PC values go into a scoreboard queue as each step
// is driven and are popped and compared once the DUT should have produced them.
module tb_pc_module;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcNext;
    logic [31:0] pc;

    logic [31:0] expQ[$];
    string       tagQ[$];
    logic [31:0] modelPc;
    int          testsRun    = 0;
    int          testsFailed = 0;

    pc_module #(
        .WIDTH      (32),
        .RESET_VALUE(32'h0000_0000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .PC_Next(pcNext),
        .PC     (pc)
    );

    always #5 clk = ~clk;

    task automatic pushExpected(input string tag, input logic [31:0] value);
        tagQ.push_back(tag);
        expQ.push_back(value);
    endtask

    task automatic checkOutput();
        logic [31:0] expected;
        string       tag;
        testsRun++;
        if (expQ.size() == 0) begin
            testsFailed++;
            $error("[TB] FAIL scoreboard_underflow: PC=%h required=<queued value>", pc);
        end else begin
            expected = expQ.pop_front();
            tag      = tagQ.pop_front();
            assert (pc === expected) else begin
                testsFailed++;
                $error("[TB] FAIL %s: PC=%h required=%h", tag, pc, expected);
            end
        end
    endtask

    // Drive a new PC_Next in the middle of the cycle (on the falling edge)
    task automatic applyStimulus(input logic [31:0] nextValue);
        @(negedge clk);
        pcNext = nextValue;
    endtask

    task automatic afterRise();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b0;
        pcNext = 'x;

        // Reset held with undriven PC_Next
        #2;
        pushExpected("reset_initial", 32'h0000_0000);
        checkOutput();
        for (int i = 0; i < 2; i++) begin
            afterRise();
            pushExpected("reset_hold", 32'h0000_0000);
            checkOutput();
        end

        // Release between edges
        @(negedge clk);
        rst    = 1'b1;
        pcNext = 32'h0000_0004;
        #1;
        pushExpected("release_before_edge", 32'h0000_0000);
        checkOutput();
        pushExpected("release_first_load", 32'h0000_0004);
        afterRise();
        checkOutput();

        // Mid-cycle load must not appear until the edge
        applyStimulus(32'h0000_0010);
        #1;
        pushExpected("load_hold_mid_cycle", 32'h0000_0004);
        checkOutput();
        #1;
        pcNext = 32'h0000_0BAD;
        #1;
        pcNext = 32'h0000_0010;
        pushExpected("load_hold_glitch", 32'h0000_0004);
        checkOutput();
        pushExpected("load_0x10", 32'h0000_0010);
        afterRise();
        checkOutput();

        // Sequential fetch from the bench's own PC model
        modelPc = 32'h0000_0010;
        for (int i = 0; i < 4; i++) begin
            modelPc = modelPc + 32'd4;
            applyStimulus(modelPc);
            pushExpected($sformatf("seq_fetch_%0d", i), modelPc);
            afterRise();
            checkOutput();
        end

        // Asynchronous reset between edges
        @(negedge clk);
        pcNext = 32'h0000_DEAD;
        #2;
        rst = 1'b0;
        #1;
        pushExpected("async_reset_immediate", 32'h0000_0000);
        checkOutput();
        afterRise();
        pushExpected("async_reset_ignores_clk", 32'h0000_0000);
        checkOutput();
        @(negedge clk);
        rst    = 1'b1;
        pcNext = 32'h0000_0100;
        #1;
        pushExpected("async_release_wait", 32'h0000_0000);
        checkOutput();
        pushExpected("async_release_load", 32'h0000_0100);
        afterRise();
        checkOutput();

        // Boundary values and unaligned address
        applyStimulus(32'hFFFF_FFFC);
        pushExpected("boundary_fffffffc", 32'hFFFF_FFFC);
        afterRise();
        checkOutput();
        applyStimulus(32'h0000_0000);
        pushExpected("boundary_wrap_zero", 32'h0000_0000);
        afterRise();
        checkOutput();
        applyStimulus(32'hFFFF_FFFF);
        pushExpected("boundary_all_ones", 32'hFFFF_FFFF);
        afterRise();
        checkOutput();
        applyStimulus(32'h0000_0003);
        pushExpected("unaligned_0x3", 32'h0000_0003);
        afterRise();
        checkOutput();

        // Reset asserted exactly on a rising edge wins over the load
        applyStimulus(32'h0000_0055);
        @(posedge clk);
        rst = 1'b0;
        #1;
        pushExpected("reset_on_edge", 32'h0000_0000);
        checkOutput();
        @(negedge clk);
        rst    = 1'b1;
        pcNext = 32'hA5A5_5A5A;
        pushExpected("after_edge_reset_load", 32'hA5A5_5A5A);
        afterRise();
        checkOutput();

        testsRun++;
        assert (expQ.size() == 0) else begin
            testsFailed++;
            $error("[TB] FAIL scoreboard_drain: pending=%0d required=0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
